// File: rtl/conv_pkg.sv
// Shared definitions for the convolution line sequencer: FSM state encoding,
// default datapath widths and a counter-width helper.
package conv_pkg;

    localparam int unsigned I_X_DEF   = 8;
    localparam int unsigned I_W_DEF   = 8;
    localparam int unsigned O_SAT_DEF = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_HOLD  = 3'd4,
        S_NEXT  = 3'd5
    } state_e;

    // Bits needed to index n entries; never returns 0 so degenerate sizes still elaborate.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_seq_window.sv
// K-deep signed pixel window: new pixels enter at win[K-1], oldest sits at win[0].
// The tap mux reads the post-shift window so the caller can register a tap in the same cycle a pixel lands.
module conv_seq_window
    import conv_pkg::*;
#(
    parameter int unsigned I_X   = I_X_DEF,
    parameter int unsigned K     = 7,
    parameter int unsigned SEL_W = cnt_w(K)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_shift,
    input  logic signed [I_X-1:0] i_x,
    input  logic [SEL_W-1:0]      i_sel,
    output logic signed [I_X-1:0] o_tap_c
);

    logic signed [I_X-1:0] win_q [K];
    logic signed [I_X-1:0] win_d [K];

    always_comb begin
        win_d = win_q;
        if (i_shift) begin
            for (int i = 0; i < int'(K) - 1; i++) begin
                win_d[i] = win_q[i + 1];
            end
            win_d[K-1] = i_x;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < int'(K); i++) begin
                win_q[i] <= '0;
            end
        end else begin
            win_q <= win_d;
        end
    end

    assign o_tap_c = win_d[i_sel];

endmodule

// File: rtl/conv_line_sequencer.sv
// Line sequencer for the convolution MAC: loads K weights, windows the pixel stream,
// issues one (x,w) tap per cycle and returns each saturated psum on a valid/ready port.
module conv_line_sequencer
    import conv_pkg::*;
#(
    parameter int unsigned I_X      = I_X_DEF,
    parameter int unsigned I_W      = I_W_DEF,
    parameter int unsigned O_SAT    = O_SAT_DEF,
    parameter int unsigned K        = 7,
    parameter int unsigned LINE_LEN = 32,
    parameter int unsigned MAC_LAT  = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_w_wr,
    input  logic signed [I_W-1:0]   i_w_data,
    output logic                    o_w_loaded,
    input  logic                    i_start,
    input  logic                    i_x_valid,
    output logic                    o_x_ready,
    input  logic signed [I_X-1:0]   i_x_data,
    output logic signed [I_X-1:0]   o_mac_x,
    output logic signed [I_W-1:0]   o_mac_w,
    output logic                    o_mac_en,
    output logic                    o_mac_clr,
    input  logic signed [O_SAT-1:0] i_mac_psum,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic signed [O_SAT-1:0] o_out_data,
    output logic                    o_done
);

    localparam int unsigned TAP_W = cnt_w(K);
    localparam int unsigned WP_W  = cnt_w(K + 1);
    localparam int unsigned PIX_W = cnt_w(LINE_LEN + 1);
    localparam int unsigned LAT_W = cnt_w(MAC_LAT);

    state_e                  state_q, state_d;
    logic [WP_W-1:0]         wptr_q, wptr_d;
    logic                    w_loaded_q, w_loaded_d;
    logic signed [I_W-1:0]   w_q [K];
    logic signed [I_W-1:0]   w_d [K];
    logic [PIX_W-1:0]        pix_q, pix_d;
    logic [TAP_W-1:0]        tap_q, tap_d;
    logic [LAT_W-1:0]        lat_q, lat_d;
    logic                    x_ready_q, x_ready_d;
    logic                    mac_en_q, mac_en_d;
    logic                    mac_clr_q, mac_clr_d;
    logic signed [I_X-1:0]   mac_x_q, mac_x_d;
    logic signed [I_W-1:0]   mac_w_q, mac_w_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [O_SAT-1:0] out_data_q, out_data_d;
    logic                    done_q, done_d;

    logic                    shift_c;
    logic                    x_acc_c;
    logic signed [I_X-1:0]   win_tap_c;

    assign x_acc_c = i_x_valid & x_ready_q;

    conv_seq_window #(
        .I_X   (I_X),
        .K     (K),
        .SEL_W (TAP_W)
    ) u_window (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_shift (shift_c),
        .i_x     (i_x_data),
        .i_sel   (tap_d),
        .o_tap_c (win_tap_c)
    );

    // Next-state, counters, weight file and result register.
    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        w_loaded_d  = w_loaded_q;
        w_d         = w_q;
        pix_d       = pix_q;
        tap_d       = tap_q;
        lat_d       = lat_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        shift_c     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (i_w_wr) begin
                    // A write after a complete load starts a fresh load at w[0].
                    if (w_loaded_q) begin
                        w_d[0]     = i_w_data;
                        wptr_d     = WP_W'(1);
                        w_loaded_d = 1'b0;
                    end else begin
                        w_d[TAP_W'(wptr_q)] = i_w_data;
                        wptr_d              = wptr_q + WP_W'(1);
                        w_loaded_d          = (wptr_q == WP_W'(K - 1));
                    end
                end else if (i_start && w_loaded_q) begin
                    state_d = S_FILL;
                    pix_d   = '0;
                end
            end
            S_FILL: begin
                if (x_acc_c) begin
                    shift_c = 1'b1;
                    pix_d   = pix_q + PIX_W'(1);
                    if (pix_q == PIX_W'(K - 1)) begin
                        state_d = S_RUN;
                        tap_d   = '0;
                    end
                end
            end
            S_RUN: begin
                if (tap_q == TAP_W'(K - 1)) begin
                    state_d = S_DRAIN;
                    lat_d   = '0;
                end else begin
                    tap_d = tap_q + TAP_W'(1);
                end
            end
            S_DRAIN: begin
                if (lat_q == LAT_W'(MAC_LAT - 1)) begin
                    out_data_d  = i_mac_psum;
                    out_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            S_HOLD: begin
                if (i_out_ready) begin
                    out_valid_d = 1'b0;
                    if (pix_q < PIX_W'(LINE_LEN)) begin
                        state_d = S_NEXT;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_NEXT: begin
                if (x_acc_c) begin
                    shift_c = 1'b1;
                    pix_d   = pix_q + PIX_W'(1);
                    state_d = S_RUN;
                    tap_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered handshake and tap outputs are decoded from the next state so they line up with it.
    always_comb begin
        x_ready_d = 1'b0;
        mac_en_d  = 1'b0;
        mac_clr_d = 1'b0;
        mac_x_d   = '0;
        mac_w_d   = '0;
        x_ready_d = (state_d == S_FILL) || (state_d == S_NEXT);
        if (state_d == S_RUN) begin
            mac_en_d  = 1'b1;
            mac_clr_d = (tap_d == '0);
            mac_x_d   = win_tap_c;
            mac_w_d   = w_q[tap_d];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            wptr_q      <= '0;
            w_loaded_q  <= 1'b0;
            for (int i = 0; i < int'(K); i++) begin
                w_q[i] <= '0;
            end
            pix_q       <= '0;
            tap_q       <= '0;
            lat_q       <= '0;
            x_ready_q   <= 1'b0;
            mac_en_q    <= 1'b0;
            mac_clr_q   <= 1'b0;
            mac_x_q     <= '0;
            mac_w_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            w_loaded_q  <= w_loaded_d;
            w_q         <= w_d;
            pix_q       <= pix_d;
            tap_q       <= tap_d;
            lat_q       <= lat_d;
            x_ready_q   <= x_ready_d;
            mac_en_q    <= mac_en_d;
            mac_clr_q   <= mac_clr_d;
            mac_x_q     <= mac_x_d;
            mac_w_q     <= mac_w_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
        end
    end

    assign o_w_loaded  = w_loaded_q;
    assign o_x_ready   = x_ready_q;
    assign o_mac_en    = mac_en_q;
    assign o_mac_clr   = mac_clr_q;
    assign o_mac_x     = mac_x_q;
    assign o_mac_w     = mac_w_q;
    assign o_out_valid = out_valid_q;
    assign o_out_data  = out_data_q;
    assign o_done      = done_q;

endmodule

// File: tb/tb_conv_line_sequencer.sv
// Scoreboard bench for conv_line_sequencer with a behavioural saturating MAC and a
// window-sum reference model.
module tb_conv_line_sequencer;

    localparam int unsigned I_X      = 8;
    localparam int unsigned I_W      = 8;
    localparam int unsigned O_SAT    = 16;
    localparam int unsigned K        = 7;
    localparam int unsigned LINE_LEN = 8;
    localparam int unsigned MAC_LAT  = 2;
    localparam int NRES = int'(LINE_LEN) - int'(K) + 1;
    localparam int LAT  = int'(K) + int'(MAC_LAT) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    i_rst, i_w_wr, i_start, i_x_valid, i_out_ready;
    logic signed [I_W-1:0]   i_w_data;
    logic signed [I_X-1:0]   i_x_data;
    logic signed [O_SAT-1:0] i_mac_psum;
    logic                    o_w_loaded, o_x_ready, o_mac_en, o_mac_clr, o_out_valid, o_done;
    logic signed [I_X-1:0]   o_mac_x;
    logic signed [I_W-1:0]   o_mac_w;
    logic signed [O_SAT-1:0] o_out_data;

    conv_line_sequencer #(
        .I_X(I_X), .I_W(I_W), .O_SAT(O_SAT), .K(K), .LINE_LEN(LINE_LEN), .MAC_LAT(MAC_LAT)
    ) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_w_wr(i_w_wr), .i_w_data(i_w_data), .o_w_loaded(o_w_loaded),
        .i_start(i_start),
        .i_x_valid(i_x_valid), .o_x_ready(o_x_ready), .i_x_data(i_x_data),
        .o_mac_x(o_mac_x), .o_mac_w(o_mac_w), .o_mac_en(o_mac_en), .o_mac_clr(o_mac_clr),
        .i_mac_psum(i_mac_psum),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
        .o_done(o_done)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit in_reset = 1'b1;
    int exp_q[$];
    int acc_edge_q[$];
    int acc_cnt = 0, run_idx = 0, res_in_line = 0, done_exp_cyc = -1, done_cnt = 0;
    bit prev_valid = 1'b0, prev_hold = 1'b0;
    logic signed [O_SAT-1:0] prev_data;
    int ready_mode = 2, stall_cnt = 0;
    int wts [K];

    int W1 [K]        = '{50, 5, 15, 50, 50, 40, 5};
    int P1 [LINE_LEN] = '{100, 10, 100, 20, 100, 10, 16, 0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sat(input longint v);
        longint mx = (longint'(1) <<< (O_SAT - 1)) - 1;
        if (v > mx) return int'(mx);
        if (v < -mx - 1) return int'(-mx - 1);
        return int'(v);
    endfunction

    function automatic int ref_result(input int px [LINE_LEN], input int r);
        longint s = 0;
        for (int t = 0; t < int'(K); t++) s += longint'(px[r + t]) * longint'(wts[t]);
        return sat(s);
    endfunction

    // Behavioural MAC: full-precision accumulate, saturate, MAC_LAT cycles to a valid psum.
    longint mac_acc = 0;
    logic signed [O_SAT-1:0] pipe [MAC_LAT];
    initial for (int i = 0; i < int'(MAC_LAT); i++) pipe[i] = '0;
    always @(posedge clk) begin
        if (o_mac_en) begin
            mac_acc = (o_mac_clr ? 64'sd0 : mac_acc) + longint'(o_mac_x) * longint'(o_mac_w);
        end
        pipe[0] <= O_SAT'(sat(mac_acc));
        for (int i = 1; i < int'(MAC_LAT); i++) pipe[i] <= pipe[i-1];
    end
    assign i_mac_psum = pipe[MAC_LAT-1];

    // Result consumer: random, 5-cycle stall per result, or always ready.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1: begin
                if (o_out_valid && stall_cnt < 5) begin
                    i_out_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    i_out_ready = o_out_valid;
                    if (!o_out_valid) stall_cnt = 0;
                end
            end
            2: i_out_ready = 1'b1;
            default: i_out_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    // Monitor: tap ordering, latency, hold stability, scoreboard pops, done pulse.
    always @(negedge clk) begin
        if (!in_reset) begin
            if (o_mac_en) begin
                chk("clr_only_tap0", o_mac_clr, (run_idx == 0));
                run_idx = (run_idx + 1) % int'(K);
            end else begin
                chk("mac_idle_zero", longint'({o_mac_clr, o_mac_x, o_mac_w}), 0);
            end
            if (i_x_valid && o_x_ready) begin
                acc_cnt++;
                if (acc_cnt >= int'(K)) acc_edge_q.push_back(cyc);
                if (acc_cnt == int'(LINE_LEN)) acc_cnt = 0;
            end
            if (o_out_valid && !prev_valid) begin
                if (acc_edge_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL out_valid_unexpected at cycle %0d", cyc);
                end else begin
                    chk("result_latency", cyc - acc_edge_q.pop_front(), LAT);
                end
            end
            if (prev_hold) begin
                chk("hold_valid", o_out_valid, 1);
                chk("hold_data", o_out_data, prev_data);
            end
            if (o_out_valid && i_out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL result_unexpected got %0d", o_out_data);
                end else begin
                    chk("result", int'(o_out_data), exp_q.pop_front());
                end
                res_in_line++;
                if (res_in_line == NRES) begin
                    res_in_line  = 0;
                    done_exp_cyc = cyc + 1;
                end
            end
            if (cyc == done_exp_cyc) begin
                chk("done_pulse", o_done, 1);
                if (o_done) done_cnt++;
            end else if (o_done) begin
                chk("done_spurious", o_done, 0);
            end
            prev_valid = o_out_valid;
            prev_hold  = o_out_valid && !i_out_ready;
            prev_data  = o_out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_reset  = 1'b1;
        i_rst     = 1'b1;
        i_start   = 1'b0;
        i_w_wr    = 1'b0;
        i_x_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("rst_x_ready", o_x_ready, 0);
        chk("rst_mac_en", o_mac_en, 0);
        chk("rst_mac_clr", o_mac_clr, 0);
        chk("rst_mac_x", o_mac_x, 0);
        chk("rst_mac_w", o_mac_w, 0);
        chk("rst_out_valid", o_out_valid, 0);
        chk("rst_out_data", o_out_data, 0);
        chk("rst_done", o_done, 0);
        chk("rst_w_loaded", o_w_loaded, 0);
        exp_q.delete();
        acc_edge_q.delete();
        acc_cnt = 0; run_idx = 0; res_in_line = 0; done_exp_cyc = -1;
        prev_valid = 1'b0; prev_hold = 1'b0;
        tick();
        i_rst    = 1'b0;
        in_reset = 1'b0;
    endtask

    task automatic load_weights(input int w [K]);
        for (int i = 0; i < int'(K); i++) begin
            if (i == int'(K) - 1) begin
                @(negedge clk);
                chk("w_loaded_early", o_w_loaded, 0);
            end
            i_w_wr   = 1'b1;
            i_w_data = I_W'(w[i]);
            wts[i]   = w[i];
            tick();
        end
        i_w_wr = 1'b0;
        @(negedge clk);
        chk("w_loaded", o_w_loaded, 1);
    endtask

    task automatic feed_px(input int v, input int gap_pct, input bit noise);
        int waited = 0;
        while (int'($urandom_range(0, 99)) < gap_pct) begin
            i_x_valid = 1'b0;
            tick();
        end
        i_x_valid = 1'b1;
        i_x_data  = I_X'(v);
        forever begin
            if (noise) i_start = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (o_x_ready) begin
                tick();
                break;
            end
            tick();
            waited++;
            if (waited > 300) begin
                checks++; errors++;
                $display("FAIL px_accept_timeout pixel %0d", v);
                break;
            end
        end
        i_x_valid = 1'b0;
        i_start   = 1'b0;
    endtask

    task automatic run_line(input int px [LINE_LEN], input int gap_pct, input bit noise);
        int d0 = done_cnt;
        for (int r = 0; r < NRES; r++) exp_q.push_back(ref_result(px, r));
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int i = 0; i < int'(LINE_LEN); i++) feed_px(px[i], gap_pct, noise);
        for (int c = 0; c < 400 && done_cnt == d0; c++) tick();
        chk("line_done", done_cnt - d0, 1);
        chk("sb_drained", exp_q.size(), 0);
        chk("w_kept", o_w_loaded, 1);
    endtask

    int wr [K];
    int pr [LINE_LEN];

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        i_rst = 1'b1; i_w_wr = 1'b0; i_w_data = '0; i_start = 1'b0;
        i_x_valid = 1'b0; i_x_data = '0; i_out_ready = 1'b0;
        do_reset();

        // Start with only part of the weights loaded must be ignored.
        for (int i = 0; i < 3; i++) begin
            i_w_wr = 1'b1; i_w_data = I_W'(i + 1); tick();
        end
        i_w_wr = 1'b0; i_start = 1'b1; tick(); i_start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("start_partial_ready", o_x_ready, 0);
            chk("start_partial_loaded", o_w_loaded, 0);
            tick();
        end
        do_reset();

        // Directed line, then same line with pixel gaps, result stalls and stray starts.
        load_weights(W1);
        ready_mode = 2;
        run_line(P1, 0, 1'b0);
        ready_mode = 1;
        run_line(P1, 50, 1'b1);

        // Weight write in the same cycle as start wins; no line starts.
        i_start = 1'b1; i_w_wr = 1'b1; i_w_data = I_W'(9);
        tick();
        i_start = 1'b0; i_w_wr = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("start_vs_wwr_ready", o_x_ready, 0);
            tick();
        end
        @(negedge clk);
        chk("start_vs_wwr_loaded", o_w_loaded, 0);
        do_reset();

        // Positive and negative saturation.
        for (int i = 0; i < int'(K); i++) wr[i] = 127;
        for (int i = 0; i < int'(LINE_LEN); i++) pr[i] = 127;
        load_weights(wr);
        ready_mode = 2;
        run_line(pr, 0, 1'b0);
        do_reset();
        for (int i = 0; i < int'(K); i++) wr[i] = -128;
        load_weights(wr);
        run_line(pr, 10, 1'b0);

        // Randomized lines.
        ready_mode = 0;
        for (int n = 0; n < 6; n++) begin
            do_reset();
            for (int i = 0; i < int'(K); i++) wr[i] = int'($urandom_range(0, 255)) - 128;
            for (int i = 0; i < int'(LINE_LEN); i++) pr[i] = int'($urandom_range(0, 255)) - 128;
            load_weights(wr);
            run_line(pr, 30, 1'b1);
        end

        // Reset while waiting on the MAC drops the pending result; reload and rerun.
        do_reset();
        load_weights(W1);
        ready_mode = 2;
        i_start = 1'b1; tick(); i_start = 1'b0;
        for (int i = 0; i < int'(K); i++) feed_px(P1[i], 0, 1'b0);
        repeat (int'(K)) tick();
        @(negedge clk);
        chk("drain_no_valid_yet", o_out_valid, 0);
        do_reset();
        repeat (int'(K) + int'(MAC_LAT) + 3) begin
            @(negedge clk);
            chk("post_rst_no_valid", o_out_valid, 0);
            tick();
        end
        load_weights(W1);
        run_line(P1, 0, 1'b0);

        repeat (5) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
